// File: rtl/blinker_pkg.sv
// Shared definitions for the blinker bank: channel mode encoding, default
// parameter values and a helper for the channel-select width.
package blinker_pkg;

  typedef enum logic [1:0] {
    ModeOff   = 2'd0,
    ModeOn    = 2'd1,
    ModeBlink = 2'd2,
    ModeBurst = 2'd3
  } blink_mode_t;

  localparam int unsigned DefCh     = 4;
  localparam int unsigned DefCntW   = 16;
  localparam int unsigned DefBurstW = 4;

  // Width of a channel index; a single-channel bank still gets a 1-bit select.
  function automatic int unsigned ch_idx_w(input int unsigned ch);
    return (ch > 1) ? $clog2(ch) : 1;
  endfunction

endpackage

// File: rtl/blinker_channel.sv
// One blinker channel: holds its own mode, phase mask, burst counter, the
// registered previous phase and the registered output/busy flags.
// Ports:
//   clk, rst_n         clock, asynchronous active-low reset
//   ena                global enable; all non-config state holds while low
//   wr                 config write strobe already decoded for this channel
//   cfg_mode/mask/burst  config fields loaded on wr
//   count              shared time-base value
//   blink, busy        registered channel output and burst-in-progress flag
module blinker_channel
  import blinker_pkg::*;
#(
  parameter int unsigned CNT_W   = DefCntW,
  parameter int unsigned BURST_W = DefBurstW
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               wr,
  input  blink_mode_t        cfg_mode,
  input  logic [CNT_W-1:0]   cfg_mask,
  input  logic [BURST_W-1:0] cfg_burst,
  input  logic [CNT_W-1:0]   count,
  output logic               blink,
  output logic               busy
);

  blink_mode_t        mode_q, mode_d;
  logic [CNT_W-1:0]   mask_q, mask_d;
  logic [BURST_W-1:0] remaining_q, remaining_d;
  logic               phase_q, phase_d;
  logic               out_q, out_d;
  logic               busy_q, busy_d;

  logic phase;
  logic rem_nz;
  logic fall;

  assign phase  = |(count & mask_q);
  assign rem_nz = (remaining_q != '0);
  assign fall   = ena & phase_q & ~phase;

  always_comb begin
    mode_d      = mode_q;
    mask_d      = mask_q;
    remaining_d = remaining_q;
    phase_d     = phase_q;
    out_d       = out_q;
    busy_d      = busy_q;

    if (ena) begin
      phase_d = phase;
      busy_d  = (mode_q == ModeBurst) & rem_nz;
      unique case (mode_q)
        ModeOff:   out_d = 1'b0;
        ModeOn:    out_d = 1'b1;
        ModeBlink: out_d = phase;
        ModeBurst: out_d = phase & rem_nz;
        default:   out_d = 1'b0;
      endcase
      // Saturating countdown of remaining pulses on each falling phase edge.
      if (fall && (mode_q == ModeBurst) && rem_nz) begin
        remaining_d = remaining_q - BURST_W'(1);
      end
    end

    // A write overrides any same-cycle decrement.
    if (wr) begin
      mode_d = cfg_mode;
      mask_d = cfg_mask;
      if (cfg_mode == ModeBurst) begin
        remaining_d = cfg_burst;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= ModeOff;
      mask_q      <= '0;
      remaining_q <= '0;
      phase_q     <= 1'b0;
      out_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      mode_q      <= mode_d;
      mask_q      <= mask_d;
      remaining_q <= remaining_d;
      phase_q     <= phase_d;
      out_q       <= out_d;
      busy_q      <= busy_d;
    end
  end

  assign blink = out_q;
  assign busy  = busy_q;

endmodule

// File: rtl/blinker_bank.sv
// Multi-channel blinker: a free-running time base shared by CH channels, each
// with its own mode and phase mask, configured through a single-cycle write port.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   ena           global enable; freezes time base and channel state when low
//   cfg_we        config write strobe
//   cfg_ch        target channel (out-of-range values write nothing)
//   cfg_mode      0=OFF 1=ON 2=BLINK 3=BURST
//   cfg_mask      phase mask for the target channel
//   cfg_burst     burst length, BURST mode only
//   blink_out     registered channel outputs
//   busy          per-channel burst-in-progress flags
//   count_out     current time-base value
module blinker_bank
  import blinker_pkg::*;
#(
  parameter int unsigned CH      = DefCh,
  parameter int unsigned CNT_W   = DefCntW,
  parameter int unsigned BURST_W = DefBurstW
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    ena,
  input  logic                    cfg_we,
  input  logic [ch_idx_w(CH)-1:0] cfg_ch,
  input  logic [1:0]              cfg_mode,
  input  logic [CNT_W-1:0]        cfg_mask,
  input  logic [BURST_W-1:0]      cfg_burst,
  output logic [CH-1:0]           blink_out,
  output logic [CH-1:0]           busy,
  output logic [CNT_W-1:0]        count_out
);

  localparam int unsigned ChW = ch_idx_w(CH);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CH-1:0]    ch_wr;

  assign count_d = ena ? (count_q + CNT_W'(1)) : count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_out = count_q;

  // Equality decode: an index at or beyond CH matches no channel, so such
  // writes fall away without side effects.
  for (genvar c = 0; c < CH; c++) begin : g_ch
    assign ch_wr[c] = cfg_we && (cfg_ch == ChW'(c));

    blinker_channel #(
      .CNT_W   (CNT_W),
      .BURST_W (BURST_W)
    ) u_channel (
      .clk       (clk),
      .rst_n     (rst_n),
      .ena       (ena),
      .wr        (ch_wr[c]),
      .cfg_mode  (blink_mode_t'(cfg_mode)),
      .cfg_mask  (cfg_mask),
      .cfg_burst (cfg_burst),
      .count     (count_q),
      .blink     (blink_out[c]),
      .busy      (busy[c])
    );
  end

endmodule

// File: tb/tb_blinker_bank.sv
module tb_blinker_bank;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ena = 1'b0;
  logic        cfg_we = 1'b0;
  logic        cfg_we_w = 1'b0;
  logic [1:0]  cfg_ch = '0;
  logic [1:0]  cfg_mode = '0;
  logic [15:0] cfg_mask = '0;
  logic [3:0]  cfg_burst = '0;

  logic [3:0]  blink_out, busy;
  logic [15:0] count_out;
  logic [2:0]  blink_w, busy_w;
  logic [3:0]  count_w;

  always #5 clk = ~clk;

  blinker_bank #(.CH(4), .CNT_W(16), .BURST_W(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .cfg_we    (cfg_we),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_mask  (cfg_mask),
    .cfg_burst (cfg_burst),
    .blink_out (blink_out),
    .busy      (busy),
    .count_out (count_out)
  );

  // Narrow 3-channel bank: exercises counter wrap and out-of-range channel select.
  blinker_bank #(.CH(3), .CNT_W(4), .BURST_W(4)) dut_w (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .cfg_we    (cfg_we_w),
    .cfg_ch    (cfg_ch),
    .cfg_mode  (cfg_mode),
    .cfg_mask  (cfg_mask[3:0]),
    .cfg_burst (cfg_burst),
    .blink_out (blink_w),
    .busy      (busy_w),
    .count_out (count_w)
  );

  int n_checks = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: per instance, per channel, plain integers.
  int nch[2]   = '{4, 3};
  int cmask[2] = '{32'hFFFF, 32'hF};
  int m_cnt[2];
  int m_mode[2][4];
  int m_mask[2][4];
  int m_rem[2][4];
  int m_phq[2][4];
  int m_out[2][4];
  int m_busy[2][4];

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_cnt[i] = 0;
      for (int c = 0; c < 4; c++) begin
        m_mode[i][c] = 0; m_mask[i][c] = 0; m_rem[i][c] = 0;
        m_phq[i][c] = 0;  m_out[i][c] = 0;  m_busy[i][c] = 0;
      end
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      bit we;
      we = (i == 0) ? cfg_we : cfg_we_w;
      for (int c = 0; c < nch[i]; c++) begin
        int ph, rem;
        ph  = ((m_cnt[i] & m_mask[i][c]) != 0) ? 1 : 0;
        rem = m_rem[i][c];
        if (ena) begin
          case (m_mode[i][c])
            0:       m_out[i][c] = 0;
            1:       m_out[i][c] = 1;
            2:       m_out[i][c] = ph;
            default: m_out[i][c] = (ph == 1 && rem != 0) ? 1 : 0;
          endcase
          m_busy[i][c] = (m_mode[i][c] == 3 && rem != 0) ? 1 : 0;
          if (m_mode[i][c] == 3 && m_phq[i][c] == 1 && ph == 0 && rem > 0) rem = rem - 1;
          m_phq[i][c] = ph;
        end
        if (we && int'(cfg_ch) == c) begin
          m_mode[i][c] = int'(cfg_mode);
          m_mask[i][c] = int'(cfg_mask) & cmask[i];
          if (cfg_mode == 2'd3) rem = int'(cfg_burst);
        end
        m_rem[i][c] = rem;
      end
      if (ena) m_cnt[i] = (m_cnt[i] + 1) & cmask[i];
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) model_reset();
    else        model_step();
  end

  // Every-cycle comparison of both banks against the reference.
  always @(negedge clk) begin
    logic [3:0] eo, eb;
    logic [2:0] wo, wb;
    if (rst_n) begin
      for (int c = 0; c < 4; c++) begin
        eo[c] = (m_out[0][c] != 0);
        eb[c] = (m_busy[0][c] != 0);
      end
      for (int c = 0; c < 3; c++) begin
        wo[c] = (m_out[1][c] != 0);
        wb[c] = (m_busy[1][c] != 0);
      end
      chk("model_blink_out", blink_out, eo);
      chk("model_busy", busy, eb);
      chk("model_count", count_out, m_cnt[0]);
      chk("model_w_blink_out", blink_w, wo);
      chk("model_w_busy", busy_w, wb);
      chk("model_w_count", count_w, m_cnt[1]);
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  // Called at a negedge; the write is sampled at the following posedge.
  task automatic wr(input bit w, input logic [1:0] ch, input logic [1:0] mode,
                    input logic [15:0] mask, input logic [3:0] burst);
    cfg_ch = ch; cfg_mode = mode; cfg_mask = mask; cfg_burst = burst;
    if (w) cfg_we_w = 1'b1;
    else   cfg_we = 1'b1;
    tick();
    cfg_we = 1'b0; cfg_we_w = 1'b0;
  endtask

  task automatic wait_cnt(input logic [2:0] low);
    int n;
    n = 0;
    while (count_out[2:0] != low && n < 16) begin
      tick();
      n++;
    end
    if (count_out[2:0] != low) chk("wait_count_timeout", count_out[2:0], low);
  endtask

  task automatic count_pulses(input int cycles, input int ch, output int pulses, output int highs);
    logic prev;
    prev = blink_out[ch];
    pulses = 0; highs = 0;
    for (int k = 0; k < cycles; k++) begin
      tick();
      if (blink_out[ch] && !prev) pulses++;
      if (blink_out[ch]) highs++;
      prev = blink_out[ch];
    end
  endtask

  initial begin
    int highs, pulses, last_t, hold_cnt, hold_out;
    logic prev;

    // Reset state
    ena = 1'b1;
    #3;
    chk("reset_blink", blink_out, 0);
    chk("reset_busy", busy, 0);
    chk("reset_count", count_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (10) tick();
    chk("count_after_10", count_out, 10);

    // Asynchronous reset mid-count
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset_count", count_out, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // BLINK on ch0, ON on ch1, OFF on ch2
    wr(0, 2'd0, 2'd2, 16'h0004, 4'd0);
    wr(0, 2'd1, 2'd1, 16'h0000, 4'd0);
    wr(0, 2'd2, 2'd0, 16'h0005, 4'd0);
    tick();
    highs = 0;
    for (int k = 0; k < 16; k++) begin
      tick();
      if (blink_out[0]) highs++;
      chk("blink_lag", blink_out[0], ((count_out - 16'd1) >> 2) & 16'd1);
      chk("on_const", blink_out[1], 1);
      chk("off_const", blink_out[2], 0);
    end
    chk("blink_highs_per_16", highs, 8);

    // BURST of 3 on ch3, written while the phase is low
    wait_cnt(3'd4);
    wr(0, 2'd3, 2'd3, 16'h0002, 4'd3);
    chk("burst_busy_pre", busy[3], 0);
    tick();
    chk("burst_busy_rise", busy[3], 1);
    count_pulses(40, 3, pulses, highs);
    chk("burst3_pulses", pulses, 3);
    chk("burst3_highs", highs, 6);
    chk("burst3_busy_end", busy[3], 0);
    chk("burst3_out_end", blink_out[3], 0);

    // Write on the same cycle as a falling edge: full reload, no decrement
    wait_cnt(3'd0);
    wr(0, 2'd3, 2'd3, 16'h0002, 4'd5);
    count_pulses(60, 3, pulses, highs);
    chk("burst5_edge_pulses", pulses, 5);
    chk("burst5_busy_end", busy[3], 0);

    // Zero-length burst never goes busy
    wr(0, 2'd2, 2'd3, 16'h0001, 4'd0);
    tick();
    for (int k = 0; k < 10; k++) begin
      tick();
      chk("burst0_busy", busy[2], 0);
      chk("burst0_out", blink_out[2], 0);
    end

    // Zero mask BURST stays busy
    wr(0, 2'd1, 2'd3, 16'h0000, 4'd7);
    tick();
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("mask0_busy", busy[1], 1);
    end

    // Freeze with ch0 still blinking; write OFF at the end of the freeze
    repeat (3) tick();
    ena = 1'b0;
    hold_cnt = m_cnt[0];
    hold_out = m_out[0][0];
    for (int k = 0; k < 19; k++) begin
      tick();
      chk("freeze_count", count_out, hold_cnt);
      chk("freeze_blink", blink_out[0], hold_out);
    end
    wr(0, 2'd0, 2'd0, 16'h0004, 4'd0);
    chk("freeze_count_last", count_out, hold_cnt);
    ena = 1'b1;
    tick();
    chk("freeze_write_off", blink_out[0], 0);

    // Out-of-range channel on the 3-channel bank
    wr(1, 2'd3, 2'd1, 16'h000F, 4'd2);
    repeat (3) tick();
    chk("oor_blink", blink_w, 0);
    chk("oor_busy", busy_w, 0);

    // 4-bit counter wrap: toggles exactly every 8 cycles
    wr(1, 2'd0, 2'd2, 16'h0008, 4'd0);
    prev = blink_w[0];
    last_t = -1;
    for (int k = 0; k < 48; k++) begin
      tick();
      if (blink_w[0] != prev) begin
        if (last_t >= 0) chk("wrap_period", k - last_t, 8);
        last_t = k;
      end
      prev = blink_w[0];
    end

    // Randomised traffic, checked by the every-cycle compare
    for (int k = 0; k < 800; k++) begin
      int r;
      ena       = ($urandom_range(0, 9) != 0);
      cfg_we    = ($urandom_range(0, 4) == 0);
      cfg_we_w  = ($urandom_range(0, 6) == 0);
      cfg_ch    = 2'($urandom_range(0, 3));
      cfg_mode  = 2'($urandom_range(0, 3));
      cfg_burst = 4'($urandom_range(0, 15));
      r = $urandom_range(0, 3);
      if (r == 0) cfg_mask = 16'h0;
      else cfg_mask = 16'(1 << $urandom_range(0, 4)) |
                      ((r == 3) ? 16'(1 << $urandom_range(0, 4)) : 16'h0);
      tick();
    end
    cfg_we = 1'b0; cfg_we_w = 1'b0; ena = 1'b1;
    tick();

    // Reset mid-burst aborts asynchronously
    wr(0, 2'd3, 2'd3, 16'h0000, 4'd9);
    tick();
    chk("abort_busy_pre", busy[3], 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk("abort_busy_async", busy, 0);
    chk("abort_blink_async", blink_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) tick();
    chk("abort_stays_off", busy[3], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/blinker_bank.md
# blinker_bank

Multi-channel, parametrised successor to the single-wire blinker. It owns a free-running time-base counter and CH independently configured channels. Each channel derives a phase bit from the counter through its own mask and drives one registered output in OFF, ON, BLINK or BURST mode. It sits between the top-level enable/IO wrapper and the LED/output pins, and is configured through a single-cycle write port.

## Interface
- CH, 4: number of channels (1–16).
- CNT_W, 16: time-base counter and mask width.
- BURST_W, 4: burst-length register width.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ena  in  1  global enable; when low, the time base and all channel state freeze.
- cfg_we  in  1  configuration write strobe, single cycle.
- cfg_ch  in  $clog2(CH) (min 1)  target channel.
- cfg_mode  in  2  0=OFF, 1=ON, 2=BLINK, 3=BURST.
- cfg_mask  in  CNT_W  phase mask for the target channel.
- cfg_burst  in  BURST_W  burst length; used in BURST mode only.
- blink_out  out  CH  registered channel outputs.
- busy  out  CH  per-channel "burst in progress" flag.
- count_out  out  CNT_W  current time-base value.

## Operation
- Time base: CNT_W-bit counter, +1 per clk while ena=1. Wraps from all-ones to 0. Holds while ena=0.
- Phase per channel: phase[c] = |(count & mask[c]). Any masked bit set means 1. This replaces the old "==1" compare.
- phase_q[c] registers phase[c] every ena cycle, regardless of mode.
- A falling edge is phase_q[c]=1 while the current phase[c]=0, with ena=1.
- Config write (cfg_we=1, cfg_ch<CH):
  - Loads mode[c] and mask[c].
  - In BURST mode it also loads remaining[c]=cfg_burst.
  - Writes are accepted regardless of ena.
  - Writes with cfg_ch≥CH are ignored with no side effects.
- Channel output next state:
  - OFF: 0.
  - ON: 1.
  - BLINK: phase[c].
  - BURST: phase[c] & (remaining[c]≠0).
- BURST mode:
  - Each falling edge decrements remaining[c], saturating at 0.
  - busy[c] = (mode=BURST) & (remaining≠0).
  - If cfg_burst=0, the output stays 0 and busy stays 0 immediately.
  - At remaining=0 the output holds 0 until the next write. The mode stays BURST.
- Simultaneous write and falling edge on the same channel: the write wins. remaining loads cfg_burst with no decrement.
- mask=0: phase is constantly 0. BLINK outputs 0. A BURST with nonzero length stays busy indefinitely; this is documented, not an error.

## Timing
- Reset (rst_n low, async): count=0, all mode=OFF, mask=0, remaining=0, phase_q=0, blink_out=0, busy=0.
- Deassertion must be synchronised externally to clk.
- blink_out and busy are registered. Their value after edge N reflects count and config as they stood before edge N.
- A write sampled at edge N changes the config registers at N. The output reflects the new config at edge N+1 (2-edge write-to-output latency).
- With ena=0: blink_out, busy, phase_q, remaining and count hold. Config writes still land.
- Reset mid-burst aborts the burst. The channel returns to OFF and busy drops asynchronously.

## Structure
- Shared package blinker_pkg holds:
  - the mode enum `blink_mode_t` (OFF, ON, BLINK, BURST), 2 bits;
  - default parameter constants.
- Top blinker_bank holds the time-base counter, the write decode and the generate loop.
- Sub-module blinker_channel holds one channel's mode, mask, remaining, phase_q and output/busy registers, with inputs count, ena, wr and cfg fields. Instantiated CH times.

## Test plan
- Reset with ena=1 and no writes: all outputs 0. count_out after 10 cycles = 10. Assert rst_n mid-count: count_out goes to 0 without waiting for clk.
- Ch0 BLINK with mask=0x0004: blink_out[0] is high for 4 cycles and low for 4, period 8, lagging count by 1 cycle. Ch1 ON and ch2 OFF are constant.
- Ch3 BURST with mask=0x0002, burst=3:
  - busy[3] rises 2 edges after the write;
  - exactly 3 high pulses of 2 cycles each;
  - busy[3] falls on the third falling edge;
  - output stays 0 afterwards.
- ena held low for 20 cycles mid-blink: count_out and blink_out are frozen. A write to ch0 (mode OFF) during the freeze drives blink_out[0] to 0 two edges later.
- Boundary cases:
  - Write on the same cycle as a ch3 falling edge with burst=5: remaining=5, no decrement.
  - Write with cfg_ch=CH: no state change.
  - burst=0: busy stays 0.
  - mask=0 BURST: busy stays 1.
- Wrap: with CNT_W=4 and mask=0x8, blink_out toggles every 8 cycles across the 0xF→0x0 wrap with no glitch.
